scalar_wb_arbiter: RTL and testbench

- Collects scalar results from N_SRC functional units (ALU, MUL, DIV, LSU) through per-source valid/ready handshakes.
- Buffers one result per source and grants up to three per cycle, round-robin.
- Drives the three scalar register-file write ports from registers, plus a matching scoreboard-clear mask.
- Sits between the execute-stage units and the scalar register file, as the writer for its write ports.

---
 rtl/tinygpu_wb_pkg.sv | 20 ++
 rtl/scalar_wb_arbiter_rr_pick3.sv | 43 ++++
 rtl/scalar_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_scalar_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinygpu_wb_pkg.sv
// Shared writeback definitions for the scalar and vector writeback paths.
package tinygpu_wb_pkg;

  localparam int N_WB_PORTS = 3;
  localparam int RD_W       = 5;
  localparam int WB_XLEN    = 32;

  // One buffered result at the default data width. Blocks with a
  // parameterised width keep rd and data as separate fields instead.
  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  // Index width for n sources. A single source still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scalar_wb_arbiter_rr_pick3.sv
// Round-robin picker: from a request vector and a start pointer, select up
// to three requesters in rotated order. Also produce the pointer that follows
// the last pick. Purely combinational.
module rr_pick3
  import tinygpu_wb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]                     req_i,
  input  logic [PW-1:0]                    start_i,
  output logic [N_WB_PORTS-1:0]            vld_o,
  output logic [N_WB_PORTS-1:0][PW-1:0]    idx_o,
  output logic [N-1:0]                     grant_o,
  output logic [PW-1:0]                    next_ptr_o
);

  // Scan from start_i, wrap around, and keep the first three hits.
  always_comb begin
    int cnt;
    int pos;
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    vld_o      = '0;
    idx_o      = '0;
    grant_o    = '0;
    next_ptr_o = start_i;
    cnt        = 0;
    pos        = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      if (req_i[pos] && cnt < N_WB_PORTS) begin
        vld_o[cnt]   = 1'b1;
        idx_o[cnt]   = PW'(pos);
        grant_o[pos] = 1'b1;
        next_ptr_o   = (pos == N - 1) ? '0 : PW'(pos + 1);
        cnt          = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: buffers one result per execute unit, then grants
// up to three per cycle round-robin onto the registered regfile write ports.
module scalar_wb_arbiter
  import tinygpu_wb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*RD_W-1:0]   src_rd,
  input  logic [N_SRC*XLEN-1:0]   src_data,
  output logic                    we0,
  output logic                    we1,
  output logic                    we2,
  output logic [RD_W-1:0]         waddr0,
  output logic [RD_W-1:0]         waddr1,
  output logic [RD_W-1:0]         waddr2,
  output logic [XLEN-1:0]         wdata0,
  output logic [XLEN-1:0]         wdata1,
  output logic [XLEN-1:0]         wdata2,
  output logic [31:0]             sb_clr,
  output logic                    busy
);

  localparam int PW = ptr_width(N_SRC);

  // Holding registers, one entry per source.
  logic [N_SRC-1:0] hold_v_q, hold_v_d;
  logic [RD_W-1:0]  hold_rd_q   [N_SRC];
  logic [RD_W-1:0]  hold_rd_d   [N_SRC];
  logic [XLEN-1:0]  hold_data_q [N_SRC];
  logic [XLEN-1:0]  hold_data_d [N_SRC];
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  // Registered write ports.
  logic [N_WB_PORTS-1:0]            we_q, we_d;
  logic [N_WB_PORTS-1:0][RD_W-1:0]  waddr_q, waddr_d;
  logic [N_WB_PORTS-1:0][XLEN-1:0]  wdata_q, wdata_d;
  logic [31:0]                      sb_clr_q, sb_clr_d;

  // Picker results.
  logic [N_WB_PORTS-1:0]            pick_vld;
  logic [N_WB_PORTS-1:0][PW-1:0]    pick_idx;
  logic [N_SRC-1:0]                 grant;
  logic [PW-1:0]                    pick_next;

  rr_pick3 #(.N(N_SRC), .PW(PW)) u_pick (
    .req_i      (hold_v_q),
    .start_i    (rr_ptr_q),
    .vld_o      (pick_vld),
    .idx_o      (pick_idx),
    .grant_o    (grant),
    .next_ptr_o (pick_next)
  );

  // A source may hand over a result when its slot is empty or being drained
  // this cycle. A draining slot is refilled with no bubble.
  assign src_ready = ~hold_v_q | grant;
  assign busy      = |hold_v_q;
  assign rr_ptr_d  = pick_next;

  // Holding register next state: accept overrides drain; rd==0 is swallowed.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        hold_v_d[i]    = |src_rd[i*RD_W +: RD_W];
        hold_rd_d[i]   = src_rd[i*RD_W +: RD_W];
        hold_data_d[i] = src_data[i*XLEN +: XLEN];
      end else if (grant[i]) begin
        hold_v_d[i] = 1'b0;
      end
    end
  end

  // Write port next state: pick order maps to port order, idle ports are zero.
  always_comb begin
    we_d     = '0;
    waddr_d  = '0;
    wdata_d  = '0;
    sb_clr_d = '0;
    for (int k = 0; k < N_WB_PORTS; k++) begin
      if (pick_vld[k]) begin
        we_d[k]    = 1'b1;
        waddr_d[k] = hold_rd_q[pick_idx[k]];
        wdata_d[k] = hold_data_q[pick_idx[k]];
        sb_clr_d   = sb_clr_d | (32'd1 << hold_rd_q[pick_idx[k]]);
      end
    end
  end

  // Control state and output ports, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      sb_clr_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      sb_clr_q <= sb_clr_d;
    end
  end

  // Holding payload storage, qualified by hold_v_q.
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays are not reset; hold_v_q gates every use, so
    // stale contents are never observed and the storage needs no reset tree.
    hold_rd_q   <= hold_rd_d;
    hold_data_q <= hold_data_d;
  end

  assign we0    = we_q[0];
  assign we1    = we_q[1];
  assign we2    = we_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wdata0 = wdata_q[0];
  assign wdata1 = wdata_q[1];
  assign wdata2 = wdata_q[2];
  assign sb_clr = sb_clr_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Testbench for scalar_wb_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model of the writeback rules.
module tb_scalar_wb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*5-1:0]  src_rd;
  logic [N*XL-1:0] src_data;
  logic            we0, we1, we2;
  logic [4:0]      waddr0, waddr1, waddr2;
  logic [XL-1:0]   wdata0, wdata1, wdata2;
  logic [31:0]     sb_clr;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  scalar_wb_arbiter #(.N_SRC(N), .XLEN(XL)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data),
    .we0(we0), .we1(we1), .we2(we2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .sb_clr(sb_clr), .busy(busy)
  );

  // Reference model: one slot per source, an integer round-robin start,
  // and the three registered write ports.
  logic [N-1:0] m_hv;
  logic [4:0]   m_rd   [N];
  logic [31:0]  m_data [N];
  int           m_ptr;
  logic [2:0]   m_we;
  logic [4:0]   m_wa   [3];
  logic [31:0]  m_wd   [3];
  logic [31:0]  m_sb;

  function automatic void model_grants(output int g[3], output int ng, output logic [N-1:0] gm);
    ng = 0;
    gm = '0;
    g  = '{0, 0, 0};
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (m_hv[p] && ng < 3) begin
        g[ng] = p;
        gm[p] = 1'b1;
        ng++;
      end
    end
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g[3];
    int ng;
    logic [N-1:0] gm;
    model_grants(g, ng, gm);
    return ~m_hv | gm;
  endfunction

  // Advance model and DUT by one clock; returns at the following negedge.
  task automatic cycle();
    int g[3];
    int ng;
    logic [N-1:0] gm, rdy;
    if (!rst_n) begin
      m_hv  = '0;
      m_ptr = 0;
      m_we  = '0;
      m_sb  = '0;
      for (int k = 0; k < 3; k++) begin m_wa[k] = '0; m_wd[k] = '0; end
    end else begin
      model_grants(g, ng, gm);
      rdy  = ~m_hv | gm;
      m_sb = '0;
      for (int k = 0; k < 3; k++) begin
        if (k < ng) begin
          m_we[k] = 1'b1;
          m_wa[k] = m_rd[g[k]];
          m_wd[k] = m_data[g[k]];
          m_sb[m_wa[k]] = 1'b1;
        end else begin
          m_we[k] = 1'b0;
          m_wa[k] = '0;
          m_wd[k] = '0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && rdy[i]) begin
          m_hv[i]   = (src_rd[i*5 +: 5] != 5'd0);
          m_rd[i]   = src_rd[i*5 +: 5];
          m_data[i] = src_data[i*XL +: XL];
        end else if (gm[i]) begin
          m_hv[i] = 1'b0;
        end
      end
      if (ng > 0) m_ptr = (g[ng-1] + 1) % N;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]         = 1'b1;
    src_rd[i*5 +: 5]     = rd;
    src_data[i*XL +: XL] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    src_valid = '1;
    src_rd    = N*5'($urandom);
    src_data  = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    cycle();
    rst_n     = 1'b1;
    src_valid = '0;
    #1;
    n_cmp++; if ({we0, we1, we2} !== 3'b000) begin n_fail++; $display("FAIL reset_we got %b want 000", {we0, we1, we2}); end
    n_cmp++; if (sb_clr !== 32'h0) begin n_fail++; $display("FAIL reset_sb_clr got %h want 0", sb_clr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (src_ready !== 4'b1111) begin n_fail++; $display("FAIL reset_ready got %b want 1111", src_ready); end
  endtask

  task automatic test_single();
    drive(0, 5'd5, 32'hDEAD_BEEF);
    cycle();
    src_valid = '0;
    n_cmp++; if (busy !== 1'b1 || we0 !== 1'b0) begin n_fail++; $display("FAIL single_t1 got busy=%b we0=%b want busy=1 we0=0", busy, we0); end
    cycle();
    n_cmp++; if (we0 !== 1'b1 || waddr0 !== 5'd5) begin n_fail++; $display("FAIL single_port0 got we0=%b waddr0=%0d want 1/5", we0, waddr0); end
    n_cmp++; if (wdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wdata0 got %h want deadbeef", wdata0); end
    n_cmp++; if (sb_clr !== 32'h0000_0020) begin n_fail++; $display("FAIL single_sb_clr got %h want 00000020", sb_clr); end
    n_cmp++; if ({we1, we2} !== 2'b00) begin n_fail++; $display("FAIL single_we12 got %b want 00", {we1, we2}); end
    cycle();
  endtask

  task automatic test_oversub();
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 5'(i + 1), 32'(8'h11 * (i + 1)));
    cycle();
    src_valid = '0;
    #1;
    n_cmp++; if (src_ready !== 4'b0111) begin n_fail++; $display("FAIL oversub_ready got %b want 0111", src_ready); end
    cycle();
    n_cmp++; if ({we0, we1, we2} !== 3'b111 || {waddr0, waddr1, waddr2} !== {5'd1, 5'd2, 5'd3})
      begin n_fail++; $display("FAIL oversub_grant1 got we=%b rd=%0d/%0d/%0d want 111 1/2/3", {we0, we1, we2}, waddr0, waddr1, waddr2); end
    n_cmp++; if ({wdata0, wdata1, wdata2} !== {32'h11, 32'h22, 32'h33})
      begin n_fail++; $display("FAIL oversub_data1 got %h/%h/%h want 11/22/33", wdata0, wdata1, wdata2); end
    n_cmp++; if (sb_clr !== 32'h0000_000E) begin n_fail++; $display("FAIL oversub_sb1 got %h want 0000000e", sb_clr); end
    cycle();
    n_cmp++; if ({we0, we1, we2} !== 3'b100 || waddr0 !== 5'd4 || wdata0 !== 32'h44)
      begin n_fail++; $display("FAIL oversub_grant2 got we=%b rd=%0d data=%h want 100 4 44", {we0, we1, we2}, waddr0, wdata0); end
    n_cmp++; if (sb_clr !== 32'h0000_0010) begin n_fail++; $display("FAIL oversub_sb2 got %h want 00000010", sb_clr); end
    // Pointer must have wrapped to 0: source 0 now outranks source 3.
    drive(3, 5'd6, 32'h66);
    drive(0, 5'd7, 32'h77);
    cycle();
    src_valid = '0;
    cycle();
    n_cmp++; if (waddr0 !== 5'd7 || waddr1 !== 5'd6 || we2 !== 1'b0)
      begin n_fail++; $display("FAIL oversub_ptr got rd=%0d/%0d we2=%b want 7/6 0", waddr0, waddr1, we2); end
    cycle();
  endtask

  task automatic test_rd0();
    drive(2, 5'd0, 32'hFFFF_FFFF);
    #1;
    n_cmp++; if (src_ready[2] !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", src_ready[2]); end
    cycle();
    src_valid = '0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd0_busy got %b want 0", busy); end
    cycle();
    n_cmp++; if ({we0, we1, we2} !== 3'b000 || sb_clr !== 32'h0)
      begin n_fail++; $display("FAIL rd0_write got we=%b sb=%h want 000 0", {we0, we1, we2}, sb_clr); end
  endtask

  task automatic test_streaming();
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive(1, 5'(8 + j), 32'h100 + 32'(j));
      else src_valid = '0;
      #1;
      if (j < 8) begin
        n_cmp++; if (src_ready[1] !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", j, src_ready[1]); end
      end
      cycle();
      if (j >= 1 && j <= 8) begin
        n_cmp++;
        if (we0 !== 1'b1 || waddr0 !== 5'(8 + j - 1) || wdata0 !== 32'h100 + 32'(j - 1) || we1 !== 1'b0)
          begin n_fail++; $display("FAIL stream_write[%0d] got we0=%b rd=%0d data=%h want 1 %0d %h", j, we0, waddr0, wdata0, 8 + j - 1, 32'h100 + 32'(j - 1)); end
      end else if (j == 9) begin
        n_cmp++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL stream_end got we0=%b want 0", we0); end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 5'd10, 32'hA0);
    drive(1, 5'd11, 32'hA1);
    drive(2, 5'd12, 32'hA2);
    cycle();
    src_valid = '0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre got %b want 1", busy); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_cmp++; if ({we0, we1, we2} !== 3'b000 || busy !== 1'b0 || sb_clr !== 32'h0)
      begin n_fail++; $display("FAIL midrst_after got we=%b busy=%b sb=%h want 000 0 0", {we0, we1, we2}, busy, sb_clr); end
    for (int j = 0; j < 4; j++) begin
      cycle();
      n_cmp++; if ({we0, we1, we2} !== 3'b000) begin n_fail++; $display("FAIL midrst_drain[%0d] got we=%b want 000", j, {we0, we1, we2}); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    for (int it = 0; it < 400; it++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      src_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        src_rd[i*5 +: 5]     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        src_data[i*XL +: XL] = $urandom;
      end
      #1;
      exp_rdy = model_ready();
      n_cmp++; if (src_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", it, src_ready, exp_rdy); end
      cycle();
      n_cmp++;
      if ({we0, we1, we2} !== {m_we[0], m_we[1], m_we[2]} ||
          {waddr0, waddr1, waddr2} !== {m_wa[0], m_wa[1], m_wa[2]} ||
          {wdata0, wdata1, wdata2} !== {m_wd[0], m_wd[1], m_wd[2]})
        begin n_fail++; $display("FAIL rand_ports[%0d] got we=%b rd=%0d/%0d/%0d want we=%b rd=%0d/%0d/%0d", it,
          {we0, we1, we2}, waddr0, waddr1, waddr2, {m_we[0], m_we[1], m_we[2]}, m_wa[0], m_wa[1], m_wa[2]); end
      n_cmp++; if (sb_clr !== m_sb || busy !== (|m_hv))
        begin n_fail++; $display("FAIL rand_sb_busy[%0d] got sb=%h busy=%b want sb=%h busy=%b", it, sb_clr, busy, m_sb, |m_hv); end
    end
    rst_n     = 1'b1;
    src_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    m_hv      = '0;
    m_ptr     = 0;
    m_we      = '0;
    m_sb      = '0;
    for (int i = 0; i < N; i++) begin m_rd[i] = '0; m_data[i] = '0; end
    for (int k = 0; k < 3; k++) begin m_wa[k] = '0; m_wd[k] = '0; end
    @(negedge clk);
    test_reset();
    test_single();
    test_oversub();
    test_rd0();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
